// File: rtl/uart_param.sv
// uart_param: parametrised full-duplex UART with RX FIFO and error flags.
//
// Parameters: DATA_W (5..9), PARITY ("NONE"/"ODD"/"EVEN"), STOP_BITS (1/2),
//             DIV (inclk cycles per bit, even, >=4), FIFO_DEPTH (power of 2).
// Ports:
//   inclk          system clock, everything on posedge
//   rst            asynchronous active-low reset
//   tx_data/tx_req client word and request (req held until tx_ack)
//   tx_ack         one-cycle pulse when tx_data has been latched
//   tx_busy        high while a frame is being transmitted
//   txd            serial output, idle high
//   rxd            serial input, asynchronous
//   rx_data/rx_perr/rx_ferr  FIFO head word and its error flags
//   rx_rdy         FIFO not empty
//   rx_ack         one-cycle pop strobe
//   rx_ovf         sticky overflow flag, cleared by the next pop
// Optional feature, macro UART_LOOPBACK_EN: adds input 'loopback'; when high
// the receiver listens to the internal transmitter and the txd pin idles high.
module uart_param #(
  parameter int    DATA_W     = 8,
  parameter string PARITY     = "ODD",
  parameter int    STOP_BITS  = 1,
  parameter int    DIV        = 16,
  parameter int    FIFO_DEPTH = 4
) (
  input  logic              inclk,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_req,
  output logic              tx_ack,
  output logic              tx_busy,
  output logic              txd,
  input  logic              rxd,
`ifdef UART_LOOPBACK_EN
  input  logic              loopback,
`endif
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_perr,
  output logic              rx_ferr,
  output logic              rx_rdy,
  input  logic              rx_ack,
  output logic              rx_ovf
);

  localparam int CW = $clog2(STOP_BITS * DIV);
  localparam int BW = $clog2(DATA_W);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam bit PAR_EN  = (PARITY != "NONE");
  localparam bit PAR_ODD = (PARITY == "ODD");
  localparam logic [CW-1:0] DIV_M1   = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_M1  = CW'(DIV / 2 - 1);
  // The final stop-bit cycle is spent in IDLE so a pending request can start
  // the next frame with no gap on the line.
  localparam logic [CW-1:0] STOP_END = CW'(STOP_BITS * DIV - 2);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PAR, ST_STOP} state_t;

  // Parity bit that the configured mode expects for a data word.
  function automatic logic f_par(input logic [DATA_W-1:0] d);
    f_par = PAR_ODD ? ~(^d) : (^d);
  endfunction

  // ---------------- transmitter ----------------
  state_t            r_tx_state, w_tx_state_nxt;
  logic [CW-1:0]     r_tx_cnt, w_tx_cnt_nxt;
  logic [BW-1:0]     r_tx_bit, w_tx_bit_nxt, w_tx_bit_inc;
  logic              r_txd, w_txd_nxt;
  logic              r_tx_ack, w_tx_ack_nxt;
  logic              r_tx_busy, w_tx_busy_nxt;
  logic              w_tx_load;
  logic [DATA_W-1:0] r_tx_data;

  assign w_tx_bit_inc = r_tx_bit + 1'b1;

  always_ff @(posedge inclk or negedge rst) begin
    if (!rst) begin
      r_tx_state <= ST_IDLE;
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
      r_txd      <= 1'b1;
      r_tx_ack   <= 1'b0;
      r_tx_busy  <= 1'b0;
    end else begin
      r_tx_state <= w_tx_state_nxt;
      r_tx_cnt   <= w_tx_cnt_nxt;
      r_tx_bit   <= w_tx_bit_nxt;
      r_txd      <= w_txd_nxt;
      r_tx_ack   <= w_tx_ack_nxt;
      r_tx_busy  <= w_tx_busy_nxt;
    end
  end

  always_ff @(posedge inclk) begin
    if (w_tx_load) r_tx_data <= tx_data;
  end

  always_comb begin
    w_tx_state_nxt = r_tx_state;
    w_tx_cnt_nxt   = r_tx_cnt + 1'b1;
    w_tx_bit_nxt   = r_tx_bit;
    w_txd_nxt      = r_txd;
    w_tx_ack_nxt   = 1'b0;
    w_tx_busy_nxt  = r_tx_busy;
    w_tx_load      = 1'b0;
    case (r_tx_state)
      ST_IDLE: begin
        w_tx_cnt_nxt = '0;
        w_txd_nxt    = 1'b1;
        if (tx_req) begin
          w_tx_load      = 1'b1;
          w_tx_state_nxt = ST_START;
          w_txd_nxt      = 1'b0;
          w_tx_ack_nxt   = 1'b1;
          w_tx_busy_nxt  = 1'b1;
        end
      end
      ST_START: begin
        if (r_tx_cnt == DIV_M1) begin
          w_tx_state_nxt = ST_DATA;
          w_tx_cnt_nxt   = '0;
          w_tx_bit_nxt   = '0;
          w_txd_nxt      = r_tx_data[0];
        end
      end
      ST_DATA: begin
        if (r_tx_cnt == DIV_M1) begin
          w_tx_cnt_nxt = '0;
          if (r_tx_bit == LAST_BIT) begin
            if (PAR_EN) begin
              w_tx_state_nxt = ST_PAR;
              w_txd_nxt      = f_par(r_tx_data);
            end else begin
              w_tx_state_nxt = ST_STOP;
              w_txd_nxt      = 1'b1;
            end
          end else begin
            w_tx_bit_nxt = w_tx_bit_inc;
            w_txd_nxt    = r_tx_data[w_tx_bit_inc];
          end
        end
      end
      ST_PAR: begin
        if (r_tx_cnt == DIV_M1) begin
          w_tx_state_nxt = ST_STOP;
          w_tx_cnt_nxt   = '0;
          w_txd_nxt      = 1'b1;
        end
      end
      ST_STOP: begin
        if (r_tx_cnt == STOP_END) begin
          w_tx_state_nxt = ST_IDLE;
          w_tx_cnt_nxt   = '0;
          w_tx_busy_nxt  = 1'b0;
        end
      end
      default: w_tx_state_nxt = ST_IDLE;
    endcase
  end

  assign tx_ack  = r_tx_ack;
  assign tx_busy = r_tx_busy;

  // ---------------- line selection / synchroniser ----------------
  logic w_rx_in;
`ifdef UART_LOOPBACK_EN
  assign w_rx_in = loopback ? r_txd : rxd;
  assign txd     = loopback ? 1'b1  : r_txd;
`else
  assign w_rx_in = rxd;
  assign txd     = r_txd;
`endif

  logic r_rxd_p0, r_rxd_p1;
  always_ff @(posedge inclk or negedge rst) begin
    if (!rst) begin
      r_rxd_p0 <= 1'b1;
      r_rxd_p1 <= 1'b1;
    end else begin
      r_rxd_p0 <= w_rx_in;
      r_rxd_p1 <= r_rxd_p0;
    end
  end

  // ---------------- receiver ----------------
  state_t            r_rx_state, w_rx_state_nxt;
  logic [CW-1:0]     r_rx_cnt, w_rx_cnt_nxt;
  logic [BW-1:0]     r_rx_bit, w_rx_bit_nxt;
  logic              r_rx_perr, w_rx_perr_nxt;
  logic              w_rx_samp, w_rx_push, w_rx_ferr;
  logic [DATA_W-1:0] r_rx_shift;

  always_ff @(posedge inclk or negedge rst) begin
    if (!rst) begin
      r_rx_state <= ST_IDLE;
      r_rx_cnt   <= '0;
      r_rx_bit   <= '0;
      r_rx_perr  <= 1'b0;
    end else begin
      r_rx_state <= w_rx_state_nxt;
      r_rx_cnt   <= w_rx_cnt_nxt;
      r_rx_bit   <= w_rx_bit_nxt;
      r_rx_perr  <= w_rx_perr_nxt;
    end
  end

  always_ff @(posedge inclk) begin
    if (w_rx_samp) r_rx_shift[r_rx_bit] <= r_rxd_p1;
  end

  always_comb begin
    w_rx_state_nxt = r_rx_state;
    w_rx_cnt_nxt   = r_rx_cnt + 1'b1;
    w_rx_bit_nxt   = r_rx_bit;
    w_rx_perr_nxt  = r_rx_perr;
    w_rx_samp      = 1'b0;
    w_rx_push      = 1'b0;
    w_rx_ferr      = 1'b0;
    case (r_rx_state)
      ST_IDLE: begin
        w_rx_cnt_nxt = '0;
        if (!r_rxd_p1) w_rx_state_nxt = ST_START;
      end
      ST_START: begin
        // Half a bit in: a line back high means the start was a glitch.
        if (r_rx_cnt == HALF_M1) begin
          w_rx_cnt_nxt   = '0;
          w_rx_bit_nxt   = '0;
          w_rx_perr_nxt  = 1'b0;
          w_rx_state_nxt = r_rxd_p1 ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (r_rx_cnt == DIV_M1) begin
          w_rx_cnt_nxt = '0;
          w_rx_samp    = 1'b1;
          if (r_rx_bit == LAST_BIT) w_rx_state_nxt = PAR_EN ? ST_PAR : ST_STOP;
          else                      w_rx_bit_nxt   = r_rx_bit + 1'b1;
        end
      end
      ST_PAR: begin
        if (r_rx_cnt == DIV_M1) begin
          w_rx_cnt_nxt   = '0;
          w_rx_perr_nxt  = (f_par(r_rx_shift) != r_rxd_p1);
          w_rx_state_nxt = ST_STOP;
        end
      end
      ST_STOP: begin
        // Only the first stop bit is checked; the frame is pushed right away.
        if (r_rx_cnt == DIV_M1) begin
          w_rx_cnt_nxt   = '0;
          w_rx_push      = 1'b1;
          w_rx_ferr      = ~r_rxd_p1;
          w_rx_state_nxt = ST_IDLE;
        end
      end
      default: w_rx_state_nxt = ST_IDLE;
    endcase
  end

  // ---------------- RX FIFO ----------------
  logic [AW:0]       r_wr_ptr, r_rd_ptr;
  logic [DATA_W+1:0] r_mem [FIFO_DEPTH];
  logic [DATA_W+1:0] w_head;
  logic              w_empty, w_full, w_pop, w_wr_en;
  logic              r_ovf;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop   = rx_ack && !w_empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO survives.
  assign w_wr_en = w_rx_push && (!w_full || w_pop);

  always_ff @(posedge inclk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)   r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_rx_push && w_full && !w_pop) r_ovf <= 1'b1;
      else if (w_pop)                    r_ovf <= 1'b0;
    end
  end

  always_ff @(posedge inclk) begin
    if (w_wr_en) r_mem[r_wr_ptr[AW-1:0]] <= {r_rx_shift, r_rx_perr, w_rx_ferr};
  end

  assign w_head  = r_mem[r_rd_ptr[AW-1:0]];
  assign rx_data = w_empty ? '0 : w_head[DATA_W+1:2];
  assign rx_perr = w_empty ? 1'b0 : w_head[1];
  assign rx_ferr = w_empty ? 1'b0 : w_head[0];
  assign rx_rdy  = !w_empty;
  assign rx_ovf  = r_ovf;

endmodule

// File: tb/tb_uart_param.sv
module tb_uart_param;
  localparam int DIV   = 16;
  localparam int DEPTH = 4;
  localparam int FRAME = 11 * DIV;

  logic       inclk = 1'b0;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_req, tx_ack, tx_busy, txd;
  logic       rxd, tb_rxd, tie;
  logic [7:0] rx_data;
  logic       rx_perr, rx_ferr, rx_rdy, rx_ack, rx_ovf;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Reference receive queue: {data, perr, ferr} per accepted frame.
  logic [9:0] q[$];
  bit         m_ovf;

  assign rxd = tie ? txd : tb_rxd;

  uart_param #(.DATA_W(8), .PARITY("ODD"), .STOP_BITS(1), .DIV(DIV), .FIFO_DEPTH(DEPTH)) dut (
    .inclk(inclk), .rst(rst),
    .tx_data(tx_data), .tx_req(tx_req), .tx_ack(tx_ack), .tx_busy(tx_busy), .txd(txd),
    .rxd(rxd),
`ifdef UART_LOOPBACK_EN
    .loopback(1'b0),
`endif
    .rx_data(rx_data), .rx_perr(rx_perr), .rx_ferr(rx_ferr), .rx_rdy(rx_rdy),
    .rx_ack(rx_ack), .rx_ovf(rx_ovf)
  );

  always #5 inclk = ~inclk;
  always @(posedge inclk) cyc++;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Odd parity: the parity bit makes the count of ones odd.
  function automatic bit model_par(input logic [7:0] d);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    return (ones % 2 == 0);
  endfunction

  function automatic void model_push(input logic [7:0] d, input bit perr, input bit ferr);
    if (q.size() < DEPTH) q.push_back({d, perr, ferr});
    else m_ovf = 1'b1;
  endfunction

  task automatic wait_ack(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge inclk);
      if (tx_ack) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("ack_timeout", 0, 1);
  endtask

  // Drive one frame on rxd; parity can be inverted, stop bit forced.
  task automatic rx_frame(input logic [7:0] d, input bit par_flip, input bit stop_val);
    @(negedge inclk);
    tb_rxd = 1'b0;
    repeat (DIV) @(negedge inclk);
    for (int i = 0; i < 8; i++) begin
      tb_rxd = d[i];
      repeat (DIV) @(negedge inclk);
    end
    tb_rxd = model_par(d) ^ par_flip;
    repeat (DIV) @(negedge inclk);
    tb_rxd = stop_val;
    repeat (DIV) @(negedge inclk);
    tb_rxd = 1'b1;
    repeat (2 * DIV) @(negedge inclk);
    model_push(d, par_flip, !stop_val);
  endtask

  task automatic pop_check(input string tag);
    @(negedge inclk);
    check({tag, "_rdy"}, 32'(rx_rdy), 32'(q.size() != 0));
    check({tag, "_ovf"}, 32'(rx_ovf), 32'(m_ovf));
    if (q.size() != 0) begin
      check({tag, "_data"}, 32'(rx_data), 32'(q[0][9:2]));
      check({tag, "_perr"}, 32'(rx_perr), 32'(q[0][1]));
      check({tag, "_ferr"}, 32'(rx_ferr), 32'(q[0][0]));
    end else begin
      check({tag, "_data_empty"}, 32'(rx_data), 0);
    end
    rx_ack = 1'b1;
    @(negedge inclk);
    rx_ack = 1'b0;
    if (q.size() != 0) begin
      q.delete(0);
      m_ovf = 1'b0;
    end
  endtask

  // Transmit a word and check every bit boundary of the line waveform.
  task automatic tx_frame_check(input logic [7:0] d, input bit expect_rx);
    logic [10:0] fb;
    bit ok;
    fb = {1'b1, model_par(d), d, 1'b0};
    @(negedge inclk);
    tx_data = d;
    tx_req  = 1'b1;
    wait_ack(40, ok);
    tx_req = 1'b0;
    if (ok) begin
      for (int i = 0; i < FRAME; i++) begin
        if (i == 1) check("tx_ack_pulse", 32'(tx_ack), 0);
        if (i == DIV * 5) check("tx_busy", 32'(tx_busy), 1);
        if (i % DIV == 0 || i % DIV == DIV - 1) check("txd_bit", 32'(txd), 32'(fb[i / DIV]));
        @(negedge inclk);
      end
      if (expect_rx) model_push(d, 1'b0, 1'b0);
      repeat (2 * DIV) @(negedge inclk);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_txd"}, 32'(txd), 1);
    check({tag, "_ack"}, 32'(tx_ack), 0);
    check({tag, "_busy"}, 32'(tx_busy), 0);
    check({tag, "_rdy"}, 32'(rx_rdy), 0);
    check({tag, "_data"}, 32'(rx_data), 0);
    check({tag, "_perr"}, 32'(rx_perr), 0);
    check({tag, "_ferr"}, 32'(rx_ferr), 0);
    check({tag, "_ovf"}, 32'(rx_ovf), 0);
  endtask

  initial begin
    int t1, t2, acks;
    bit ok;
    rst = 1'b0; tie = 1'b0; tb_rxd = 1'b1;
    tx_req = 1'b0; tx_data = '0; rx_ack = 1'b0; m_ovf = 1'b0;
    repeat (3) @(negedge inclk);
    check_reset_outputs("rst0");
    rst = 1'b1;
    acks = 0;
    repeat (10) begin
      @(negedge inclk);
      if (tx_ack) acks++;
    end
    check("idle_no_ack", acks, 0);

    // Round trip through the line.
    tie = 1'b1;
    tx_frame_check(8'h55, 1'b1);
    pop_check("rt55");
    tie = 1'b0;

    // Parity error: 0xA3 with parity bit 0.
    rx_frame(8'hA3, 1'b1, 1'b1);
    pop_check("perr");

    // Framing error followed by a good frame.
    rx_frame(8'h3C, 1'b0, 1'b0);
    rx_frame(8'h12, 1'b0, 1'b1);
    pop_check("ferr");
    pop_check("after_ferr");

    // Overflow with five frames into a four-entry FIFO.
    for (int i = 1; i <= 5; i++) rx_frame(8'(i), 1'b0, 1'b1);
    @(negedge inclk);
    check("ovf_set", 32'(rx_ovf), 1);
    for (int i = 0; i < 5; i++) pop_check("ovf_pop");
    check("ovf_empty_rdy", 32'(rx_rdy), 0);
    check("ovf_cleared", 32'(rx_ovf), 0);

    // Short low glitch must not produce a frame.
    @(negedge inclk);
    tb_rxd = 1'b0;
    repeat (4) @(negedge inclk);
    tb_rxd = 1'b1;
    repeat (3 * DIV) @(negedge inclk);
    check("glitch_rdy", 32'(rx_rdy), 0);

    // Back-to-back transmission with req held high.
    tie = 1'b1;
    @(negedge inclk);
    tx_data = 8'hFF;
    tx_req  = 1'b1;
    wait_ack(40, ok);
    t1 = cyc;
    tx_data = 8'h00;
    wait_ack(FRAME + 40, ok);
    t2 = cyc;
    tx_req = 1'b0;
    check("b2b_spacing", t2 - t1, FRAME);
    model_push(8'hFF, 1'b0, 1'b0);
    model_push(8'h00, 1'b0, 1'b0);
    repeat (FRAME + 3 * DIV) @(negedge inclk);
    pop_check("b2b_ff");
    pop_check("b2b_00");

    // Random loopback words.
    for (int k = 0; k < 3; k++) begin
      tx_frame_check(8'($urandom_range(0, 255)), 1'b1);
      pop_check("rnd_tx");
    end
    tie = 1'b0;

    // Random receive traffic with injected errors and irregular pops.
    for (int k = 0; k < 24; k++) begin
      logic [7:0] d;
      bit pf, sv;
      d  = 8'($urandom_range(0, 255));
      pf = ($urandom_range(0, 3) == 0);
      sv = ($urandom_range(0, 4) != 0);
      rx_frame(d, pf, sv);
      if ($urandom_range(0, 1) == 1) pop_check("rnd_rx");
    end
    while (q.size() != 0) pop_check("drain");

    // Reset in the middle of a transmitted frame with data queued.
    rx_frame(8'h5A, 1'b0, 1'b1);
    @(negedge inclk);
    tx_data = 8'h00;
    tx_req  = 1'b1;
    wait_ack(40, ok);
    tx_req = 1'b0;
    repeat (40) @(negedge inclk);
    check("pre_rst_txd", 32'(txd), 0);
    check("pre_rst_rdy", 32'(rx_rdy), 1);
    #2 rst = 1'b0;
    #1 check_reset_outputs("rst_mid");
    q.delete();
    m_ovf = 1'b0;
    @(negedge inclk);
    rst = 1'b1;
    acks = 0;
    repeat (20) begin
      @(negedge inclk);
      if (tx_ack) acks++;
    end
    check("post_rst_no_ack", acks, 0);
    check("post_rst_txd", 32'(txd), 1);
    check("post_rst_busy", 32'(tx_busy), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/uart_param.md
Name: uart_param

Overview:
- Parametrised full-duplex UART, successor to the fixed-format uart block.
- Configurable data width, parity mode, stop bits and clocks-per-bit.
- Adds an RX FIFO, parity/framing/overflow error flags and an RX start-bit glitch filter.
- Sits between a parallel req/ack client and the serial pins txd/rxd.

Parameters:
- DATA_W, 8, data bits per frame; legal 5..9.
- PARITY, "ODD", "NONE" / "ODD" / "EVEN".
- STOP_BITS, 1, stop bits transmitted; legal 1 or 2.
- DIV, 16, inclk cycles per bit; even, >=4.
- FIFO_DEPTH, 4, RX FIFO entries; power of 2, >=2.

Ports:
- inclk  in  1  system clock; all logic on posedge.
- rst  in  1  reset, asynchronous, active-low.
- tx_data  in  DATA_W  word to transmit.
- tx_req  in  1  transmit request, held high by the client until tx_ack.
- tx_ack  out  1  one-cycle pulse: tx_data latched.
- tx_busy  out  1  high from acceptance until the last stop bit completes.
- txd  out  1  serial output, idle high.
- rxd  in  1  serial input, asynchronous.
- rx_data  out  DATA_W  FIFO head data.
- rx_perr  out  1  FIFO head parity error (always 0 when PARITY="NONE").
- rx_ferr  out  1  FIFO head framing error.
- rx_rdy  out  1  FIFO not empty.
- rx_ack  in  1  one-cycle pop strobe.
- rx_ovf  out  1  sticky overflow flag.

Behaviour:
- Reset (rst=0, async): txd=1, tx_ack=0, tx_busy=0, rx_rdy=0, rx_data=0, rx_perr=0, rx_ferr=0, rx_ovf=0, FIFO emptied, both FSMs IDLE, counters 0.
- Reset mid-frame: the frame is aborted and txd goes high immediately.
- Frame format: start(0), DATA_W bits LSB first, parity bit (omitted for NONE), STOP_BITS ones.
- Every bit lasts exactly DIV cycles.
- ODD parity bit makes the total ones in data+parity odd; EVEN makes it even.
- TX FSM states: IDLE, START, DATA, PAR, STOP.
- IDLE with tx_req=1: latch tx_data, pulse tx_ack for 1 cycle, assert tx_busy, go to START. txd drops on the next cycle.
- START -> DATA after DIV cycles.
- DATA -> PAR (or STOP if NONE) after DATA_W bits.
- PAR -> STOP after DIV cycles.
- STOP -> IDLE after STOP_BITS*DIV cycles, with tx_busy cleared in the same cycle.
- tx_req is sampled only in IDLE. A req still high on the first IDLE cycle starts a back-to-back frame with no idle gap.
- rxd passes through a 2-flop synchroniser before any use.
- RX FSM states: IDLE, START, DATA, PAR, STOP.
- IDLE: synchronised rxd=0 -> START.
- START: wait DIV/2 cycles, then resample. If rxd=1 the start was a glitch: return to IDLE, nothing pushed. If rxd=0 -> DATA.
- DATA/PAR/STOP: sample every DIV cycles (mid-bit).
- Only the first stop bit is checked. Stop sample 0 sets ferr for that frame.
- Parity mismatch sets perr for that frame.
- After the stop sample: push {data, perr, ferr} and return to IDLE. RX does not wait for a second stop bit.
- Frames with errors are still pushed.
- Push when full: the frame is dropped and rx_ovf is set. rx_ovf stays high until the next rx_ack.
- Push and rx_ack on the same cycle while full: the pop frees the slot and the push succeeds, with no overflow.
- rx_ack while empty is ignored.
- rx_data, rx_perr and rx_ferr present the FIFO head. They update the cycle after a pop. First-entry latency from write to rx_rdy is 1 cycle.
- Pointers are $clog2(FIFO_DEPTH)+1 bits wide, with wrap-around via the MSB.
- Occupancy ordering is strict FIFO.

Optional Feature:
- Macro: UART_LOOPBACK_EN.
- Defined: adds input port loopback (1 bit).
  - When loopback=1, the RX synchroniser input is internal txd and the external txd pin is held at 1.
  - Switching loopback mid-frame may produce a framing error; no other effect.
- Undefined: no loopback port; RX always uses the rxd pin.

Test Plan:
- Reset check: assert rst=0 mid-TX-frame -> txd=1 and all outputs at reset values within the same cycle; after release, tx_ack stays 0 until tx_req.
- TX/RX round trip (DATA_W=8, ODD, DIV=16, txd tied to rxd):
  - Send 0x55 -> tx_ack one pulse.
  - txd carries 0,1,0,1,0,1,0,1,0, parity 1, stop 1 across 176 cycles.
  - rx_rdy rises, rx_data=0x55, rx_perr=0, rx_ferr=0.
- Parity error: drive rxd frame with data 0xA3 and parity bit 0 (ODD) -> rx_data=0xA3, rx_perr=1, rx_ferr=0.
- Framing error: drive 0x3C with stop bit 0 -> rx_ferr=1, entry pushed.
  - RX returns to IDLE, and a following good frame 0x12 is received correctly.
- Overflow: 5 frames 0x01..0x05 with no rx_ack, FIFO_DEPTH=4 -> rx_ovf=1.
  - Pops return 0x01..0x04, then rx_rdy=0.
  - rx_ovf clears on the first rx_ack.
- Glitch and back-to-back:
  - rxd low for 4 cycles -> no push.
  - tx_req held high across two words 0xFF,0x00 -> two tx_ack pulses 176 cycles apart; both words received.
